// File: rtl/sm_pkg.sv
// Shared types, register offsets and the sign-magnitude to two's-complement helper
// for the sign-magnitude result FIFO.
package sm_pkg;

   localparam int NUM = 18;

   localparam logic [1:0] REG_STATUS  = 2'd0;
   localparam logic [1:0] REG_DATA_SM = 2'd1;
   localparam logic [1:0] REG_DATA_TC = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int CTRL_FLUSH    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_DROP_CLR = 2;
   localparam int CTRL_FORCE    = 3;

   typedef logic [NUM:0] sm_word_t;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_ACK  = 1'b1
   } wb_state_t;

   // Negate the zero-extended magnitude in NUM+1 bits, then sign-extend to 32 bits.
   // The magnitude never exceeds 2^NUM-1, so the negation cannot overflow.
   function automatic logic [31:0] sm_to_tc(input sm_word_t sm);
      logic signed [NUM:0] mag_s;
      logic signed [NUM:0] tc_s;
      mag_s = signed'({1'b0, sm[NUM-1:0]});
      tc_s  = sm[NUM] ? -mag_s : mag_s;
      return 32'(tc_s);
   endfunction

endpackage

// File: rtl/sm_fifo.sv
// Synchronous FIFO of sign-magnitude words with wrap-bit pointers and a
// combinational head. Flush takes priority over push and pop.
module sm_fifo import sm_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  sm_word_t                 din,
   output sm_word_t                 head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   sm_word_t    mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_push;
   logic        do_pop;

   // A pop frees a slot in the same cycle, so a push to a full FIFO is allowed alongside it.
   assign do_pop  = pop & !empty;
   assign do_push = push & (!full | do_pop);

   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

   // Pointer update; flush and reset both return the FIFO to empty.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers qualify them.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/sm_result_fifo_wb.sv
// Captures sign-magnitude adder results into a FIFO and lets the SoC drain them over
// Wishbone as sign-magnitude or two's-complement words, with a pending-data IRQ.
module sm_result_fifo_wb import sm_pkg::*; #(
   parameter int          NUM       = sm_pkg::NUM,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
   input  logic           wb_clk_i,
   input  logic           wb_rst_i,
   input  logic           res_valid_i,
   input  logic [NUM:0]   res_sum_i,
   output logic           res_ready_o,
   input  logic           wbs_stb_i,
   input  logic           wbs_cyc_i,
   input  logic           wbs_we_i,
   input  logic [3:0]     wbs_sel_i,
   input  logic [31:0]    wbs_adr_i,
   input  logic [31:0]    wbs_dat_i,
   output logic           wbs_ack_o,
   output logic [31:0]    wbs_dat_o,
   output logic           irq_o
);

   sm_word_t                sum_norm;
   sm_word_t                head;
   logic [$clog2(DEPTH):0]  count;
   logic                    full;
   logic                    empty;
   logic                    push;
   logic                    pop;
   logic                    flush;
   logic                    drop;
   logic                    drop_clr;
   logic                    ctrl_wr;
   logic                    req;
   logic                    hit;
   logic [1:0]              reg_idx;
   logic                    ctrl_irq_en;
   logic                    ctrl_force;
   logic [7:0]              drop_cnt;
   logic                    irq_q;
   wb_state_t               state;
   wb_state_t               state_nxt;
   logic [31:0]             rd_mux;
   logic [31:0]             rd_data_q;
   logic                    unused_bits;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:4], wbs_sel_i[3:1]};

   // Capture side: negative zero is folded to +0 before storage.
   assign sum_norm    = (res_sum_i[NUM-1:0] == '0) ? '0 : res_sum_i;
   assign res_ready_o = !full | ctrl_force;
   assign push        = res_valid_i & res_ready_o & !full;
   assign drop        = res_valid_i & ctrl_force & full & !flush;

   // Bus decode; side effects are qualified by the IDLE->ACK request edge.
   assign hit      = (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
   assign reg_idx  = wbs_adr_i[3:2];
   assign pop      = req & !wbs_we_i & !empty &
                     ((reg_idx == REG_DATA_SM) || (reg_idx == REG_DATA_TC));
   assign ctrl_wr  = req & wbs_we_i & (reg_idx == REG_CTRL) & wbs_sel_i[0];
   assign flush    = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
   assign drop_clr = ctrl_wr & wbs_dat_i[CTRL_DROP_CLR];

   assign wbs_ack_o = (state == WB_ACK);
   assign wbs_dat_o = rd_data_q;
   assign irq_o     = irq_q;

   sm_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (sum_norm),
      .head  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Wishbone state register.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= WB_IDLE;
      else          state <= state_nxt;
   end

   // Wishbone next state: accept a hit in IDLE, acknowledge for exactly one cycle.
   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      case (state)
         WB_IDLE: begin
            if (wbs_stb_i && wbs_cyc_i && hit) begin
               req       = 1'b1;
               state_nxt = WB_ACK;
            end
         end
         WB_ACK:  state_nxt = WB_IDLE;
         default: state_nxt = WB_IDLE;
      endcase
   end

   // Read data selection; empty DATA reads and all writes return zero.
   always_comb begin
      rd_mux = '0;
      if (!wbs_we_i) begin
         case (reg_idx)
            REG_STATUS:  rd_mux = {16'h0, drop_cnt, 2'b00, full, empty, 4'(count)};
            REG_DATA_SM: rd_mux = empty ? 32'h0 : 32'(head);
            REG_DATA_TC: rd_mux = empty ? 32'h0 : sm_to_tc(head);
            REG_CTRL:    rd_mux = {28'h0, ctrl_force, 1'b0, ctrl_irq_en, 1'b0};
            default:     rd_mux = '0;
         endcase
      end
   end

   // Read data is latched on the request edge and held only through the ack cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)  rd_data_q <= '0;
      else if (req)  rd_data_q <= rd_mux;
      else           rd_data_q <= '0;
   end

   // Persistent CTRL bits; flush and drop_clr act as strobes and are not stored.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ctrl_irq_en <= 1'b0;
         ctrl_force  <= 1'b0;
      end else if (ctrl_wr) begin
         ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
         ctrl_force  <= wbs_dat_i[CTRL_FORCE];
      end
   end

   // Saturating drop counter; a clear wins over a same-cycle drop.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)      drop_cnt <= '0;
      else if (drop_clr) drop_cnt <= '0;
      else if (drop)     drop_cnt <= sat_inc8(drop_cnt);
   end

   // Registered pending-data interrupt.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) irq_q <= 1'b0;
      else          irq_q <= ctrl_irq_en & !empty;
   end

endmodule
